// File: rtl/quiz_pkg.sv
// Shared state encoding and player/winner codes for the quiz round sequencer.
package quiz_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_ANSWER,
    ST_CLEAR,
    ST_DONE
  } state_e;

  localparam logic [1:0] WHO_NONE = 2'b00;
  localparam logic [1:0] WHO_P1   = 2'b01;
  localparam logic [1:0] WHO_P2   = 2'b10;
  localparam logic [1:0] WHO_TIE  = 2'b11;

endpackage

// File: rtl/answer_timer.sv
// Answer-window down counter: load sets CYCLES-1, counts down while enabled, holds at zero.
// expire_o is high whenever the count has reached zero.
module answer_timer #(
  parameter int CYCLES = 16,
  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = W'(CYCLES - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/quiz_round_ctrl.sv
// Buzzer-game round sequencer: arm, capture winner, timed answer, score, clear, repeat ROUNDS times.
// Outputs are registered from the current state; define QUIZ_LOCKOUT_EN to lock out the last miss.
module quiz_round_ctrl
  import quiz_pkg::*;
#(
  parameter int ANSWER_CYCLES = 16,
  parameter int ROUNDS        = 8,
  parameter int SCORE_W       = 4,
  localparam int RC_W         = $clog2(ROUNDS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               savewho1,
  input  logic               savewho2,
  input  logic               judge_ok,
  input  logic               judge_bad,
  output logic [1:0]         arm,
  output logic               finish,
  output logic [1:0]         turn,
  output logic               timeout,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [RC_W-1:0]    round_cnt,
  output logic               game_over,
  output logic [1:0]         winner
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  state_e             state_q, state_d;
  logic [1:0]         arm_q, turn_q, winner_q, who_q;
  logic               finish_q, timeout_q, game_over_q;
  logic               point_q, tout_q;
  logic [SCORE_W-1:0] score1_q, score2_q;
  logic [RC_W-1:0]    round_cnt_q;

  logic [1:0] buzz_who, arm_mask, final_winner;
  logic       timer_load, timer_en, expire, end_answer, start_game, last_round;

  answer_timer #(.CYCLES(ANSWER_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (timer_load),
    .en_i     (timer_en),
    .expire_o (expire)
  );

  assign timer_en   = (state_q == ST_ANSWER);
  assign start_game = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_round = (round_cnt_q + RC_W'(1)) == RC_W'(ROUNDS);

`ifdef QUIZ_LOCKOUT_EN
  logic [1:0] lock_q;

  // who_q's one-hot code doubles as the arm bit to suppress next round.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q <= 2'b00;
    end else if (start_game) begin
      lock_q <= 2'b00;
    end else if (state_q == ST_CLEAR) begin
      lock_q <= point_q ? WHO_NONE : who_q;
    end
  end

  assign arm_mask = ~lock_q;
`else
  assign arm_mask = 2'b11;
`endif

  always_comb begin
    state_d    = state_q;
    buzz_who   = WHO_NONE;
    timer_load = 1'b0;
    end_answer = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        // Gating on the registered arm keeps a stale buzz from the last round out.
        if (savewho1 && arm_q[0]) begin
          buzz_who = WHO_P1;
        end else if (savewho2 && arm_q[1]) begin
          buzz_who = WHO_P2;
        end
        if (buzz_who != WHO_NONE) begin
          state_d    = ST_ANSWER;
          timer_load = 1'b1;
        end
      end
      ST_ANSWER: begin
        if (judge_ok || judge_bad || expire) begin
          state_d    = ST_CLEAR;
          end_answer = 1'b1;
        end
      end
      ST_CLEAR: begin
        state_d = last_round ? ST_DONE : ST_ARMED;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    final_winner = WHO_TIE;
    if (score1_q > score2_q) begin
      final_winner = WHO_P1;
    end else if (score2_q > score1_q) begin
      final_winner = WHO_P2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arm_q       <= 2'b00;
      turn_q      <= WHO_NONE;
      finish_q    <= 1'b0;
      timeout_q   <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= WHO_NONE;
      who_q       <= WHO_NONE;
      point_q     <= 1'b0;
      tout_q      <= 1'b0;
      score1_q    <= '0;
      score2_q    <= '0;
      round_cnt_q <= '0;
    end else begin
      arm_q       <= (state_q == ST_ARMED) ? arm_mask : 2'b00;
      turn_q      <= (state_q == ST_ANSWER) ? who_q : WHO_NONE;
      finish_q    <= (state_q == ST_CLEAR);
      timeout_q   <= (state_q == ST_CLEAR) && tout_q;
      game_over_q <= (state_q == ST_DONE);
      winner_q    <= (state_q == ST_DONE) ? final_winner : WHO_NONE;

      if (timer_load) who_q <= buzz_who;

      // A simultaneous ok/bad counts as bad; only silence at expiry is a timeout.
      if (end_answer) begin
        point_q <= judge_ok && !judge_bad;
        tout_q  <= !(judge_ok || judge_bad);
      end

      if (state_q == ST_CLEAR) begin
        round_cnt_q <= round_cnt_q + RC_W'(1);
        if (point_q && (who_q == WHO_P1) && (score1_q != SCORE_MAX)) begin
          score1_q <= score1_q + SCORE_W'(1);
        end
        if (point_q && (who_q == WHO_P2) && (score2_q != SCORE_MAX)) begin
          score2_q <= score2_q + SCORE_W'(1);
        end
      end

      if (start_game) begin
        score1_q    <= '0;
        score2_q    <= '0;
        round_cnt_q <= '0;
      end
    end
  end

  assign arm       = arm_q;
  assign finish    = finish_q;
  assign turn      = turn_q;
  assign timeout   = timeout_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign round_cnt = round_cnt_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Directed bench for quiz_round_ctrl: per-cycle vector table for the first two rounds,
// then hand sequences for timeout, last-cycle verdict, lockout, saturation, game end and reset.
module tb_quiz_round_ctrl;

  localparam int SW   = 2;
  localparam int RC_W = 4;

`ifdef QUIZ_LOCKOUT_EN
  localparam logic [1:0] ARM_AFTER_BAD = 2'b10;
  localparam logic [1:0] ARM_AFTER_TO  = 2'b01;
`else
  localparam logic [1:0] ARM_AFTER_BAD = 2'b11;
  localparam logic [1:0] ARM_AFTER_TO  = 2'b11;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, savewho1 = 1'b0, savewho2 = 1'b0, judge_ok = 1'b0, judge_bad = 1'b0;
  logic [1:0]      arm, turn, winner;
  logic            finish, timeout, game_over;
  logic [SW-1:0]   score1, score2;
  logic [RC_W-1:0] round_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  quiz_round_ctrl #(.ANSWER_CYCLES(16), .ROUNDS(8), .SCORE_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .savewho1  (savewho1),
    .savewho2  (savewho2),
    .judge_ok  (judge_ok),
    .judge_bad (judge_bad),
    .arm       (arm),
    .finish    (finish),
    .turn      (turn),
    .timeout   (timeout),
    .score1    (score1),
    .score2    (score2),
    .round_cnt (round_cnt),
    .game_over (game_over),
    .winner    (winner)
  );

  // {arm, finish, turn, timeout, score1, score2, round_cnt, game_over, winner}
  typedef logic [16:0] obs_t;

  typedef struct {
    logic st, s1, s2, ok, bad;
    obs_t exp;
  } vec_t;

  function automatic obs_t pk(logic [1:0] a, logic f, logic [1:0] t, logic to,
                              logic [1:0] s1, logic [1:0] s2, logic [3:0] rc,
                              logic go, logic [1:0] w);
    return {a, f, t, to, s1, s2, rc, go, w};
  endfunction

  function automatic obs_t observed();
    return {arm, finish, turn, timeout, score1, score2, round_cnt, game_over, winner};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // P1 buzzes, ok two cycles later; checks the CLEAR cycle and the cycle after.
  task automatic play_round_p1(input logic [1:0] exp_s1, input logic [3:0] exp_rc,
                               input logic last);
    savewho1 = 1'b1;
    tick();
    tick();
    judge_ok = 1'b1;
    tick();
    judge_ok = 1'b0;
    tick();
    check("round_finish", finish, 1'b1);
    check("round_score1", score1, exp_s1);
    check("round_cnt", round_cnt, exp_rc);
    savewho1 = 1'b0;
    tick();
    if (last) begin
      check("game_over", game_over, 1'b1);
      check("winner", winner, 2'b01);
      check("done_arm", arm, 2'b00);
    end else begin
      check("rearm", arm, 2'b11);
    end
  endtask

  vec_t vecs[14];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic early;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, pk(2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00)};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pk(2'b11, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00)};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pk(2'b11, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00)};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pk(2'b00, 0, 2'b01, 0, 0, 0, 0, 0, 2'b00)};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, pk(2'b00, 0, 2'b01, 0, 0, 0, 0, 0, 2'b00)};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pk(2'b00, 1, 2'b00, 0, 1, 0, 1, 0, 2'b00)};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pk(2'b11, 0, 2'b00, 0, 1, 0, 1, 0, 2'b00)};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, pk(2'b11, 0, 2'b00, 0, 1, 0, 1, 0, 2'b00)};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, pk(2'b11, 0, 2'b00, 0, 1, 0, 1, 0, 2'b00)};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, pk(2'b00, 0, 2'b01, 0, 1, 0, 1, 0, 2'b00)};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, pk(2'b00, 0, 2'b01, 0, 1, 0, 1, 0, 2'b00)};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, pk(2'b00, 1, 2'b00, 0, 1, 0, 2, 0, 2'b00)};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, pk(ARM_AFTER_BAD, 0, 2'b00, 0, 1, 0, 2, 0, 2'b00)};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pk(ARM_AFTER_BAD, 0, 2'b00, 0, 1, 0, 2, 0, 2'b00)};

    // Reset state
    tick();
    check("reset_outputs", observed(), '0);
    rst = 1'b1;
    tick();
    check("idle_outputs", observed(), '0);

    // Rounds 1-2, cycle by cycle
    for (int i = 0; i < 14; i++) begin
      start     = vecs[i].st;
      savewho1  = vecs[i].s1;
      savewho2  = vecs[i].s2;
      judge_ok  = vecs[i].ok;
      judge_bad = vecs[i].bad;
      tick();
      check($sformatf("vec%0d", i), observed(), vecs[i].exp);
    end
    start = 1'b0; savewho1 = 1'b0; savewho2 = 1'b0; judge_ok = 1'b0; judge_bad = 1'b0;

    // Round 3: P2 answers nothing, window expires
    savewho2 = 1'b1;
    tick();
    early = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 1) check("p2_turn", turn, 2'b10);
      if (timeout || finish) early = 1'b1;
    end
    check("no_early_timeout", early, 1'b0);
    tick();
    check("timeout_pulse", timeout, 1'b1);
    check("timeout_finish", finish, 1'b1);
    check("timeout_scores", {score1, score2}, {2'd1, 2'd0});
    check("timeout_rc", round_cnt, 4'd3);
    savewho2 = 1'b0;
    tick();
    check("timeout_single", timeout, 1'b0);
    check("arm_after_timeout", arm, ARM_AFTER_TO);

    // Round 4: locked player's buzz ignored; P1 verdict on the final window cycle
`ifdef QUIZ_LOCKOUT_EN
    savewho2 = 1'b1;
    tick();
    tick();
    check("locked_buzz_turn", turn, 2'b00);
    check("locked_arm", arm, 2'b01);
    savewho2 = 1'b0;
`endif
    savewho1 = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) tick();
    judge_ok = 1'b1;
    tick();
    judge_ok = 1'b0;
    check("last_cycle_no_finish_yet", finish, 1'b0);
    tick();
    check("last_cycle_finish", finish, 1'b1);
    check("last_cycle_no_timeout", timeout, 1'b0);
    check("last_cycle_score1", score1, 2'd2);
    check("last_cycle_rc", round_cnt, 4'd4);
    savewho1 = 1'b0;
    tick();
    check("arm_lock_cleared", arm, 2'b11);

    // Rounds 5-8: saturation and game end
    play_round_p1(2'd3, 4'd5, 1'b0);
    play_round_p1(2'd3, 4'd6, 1'b0);
    play_round_p1(2'd3, 4'd7, 1'b0);
    play_round_p1(2'd3, 4'd8, 1'b1);

    // Restart from DONE
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_clear", {score1, score2, round_cnt}, '0);
    tick();
    check("restart_armed", {arm, game_over}, {2'b11, 1'b0});
    play_round_p1(2'd1, 4'd1, 1'b0);

    // Asynchronous reset in the middle of an answer window
    savewho1 = 1'b1;
    tick();
    tick();
    check("pre_reset_turn", turn, 2'b01);
    rst = 1'b0;
    #1;
    check("async_reset_outputs", observed(), '0);
    savewho1 = 1'b0;
    tick();
    rst = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    play_round_p1(2'd1, 4'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quiz_round_ctrl.md
# quiz_round_ctrl

Round sequencer for the two-player buzzer game. Arms the `who_push` capture block, waits for a winner, runs a bounded answer window, applies the host judge's verdict to saturating per-player scores, and pulses `finish` to clear the capture before re-arming. A game is a fixed number of rounds, after which the block reports the overall winner.

## Interface
- `ANSWER_CYCLES`, 16: answer-window length in clocks, minimum 2.
- `ROUNDS`, 8: rounds per game, minimum 1.
- `SCORE_W`, 4: score width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse that begins a new game.
- `savewho1`  in  1  level from `who_push`: player 1 buzzed first.
- `savewho2`  in  1  level from `who_push`: player 2 buzzed first.
- `judge_ok`  in  1  pulse: the answer is correct.
- `judge_bad`  in  1  pulse: the answer is wrong.
- `arm`  out  2  per-player capture enable, bit0 for P1 and bit1 for P2.
- `finish`  out  1  one-cycle pulse that clears `who_push`.
- `turn`  out  2  current answerer: 00 none, 01 P1, 10 P2.
- `timeout`  out  1  one-cycle pulse when the answer window expires.
- `score1`, `score2`  out  SCORE_W  player scores.
- `round_cnt`  out  $clog2(ROUNDS+1)  rounds completed.
- `game_over`  out  1  high in DONE.
- `winner`  out  2  valid in DONE: 01 P1, 10 P2, 11 tie.

## Operation
- **IDLE**
  - `arm`=00.
  - `start` clears the scores and `round_cnt`, then goes to ARMED.
- **ARMED**
  - `arm`=11, or the lockout mask when that feature is compiled in.
  - If `savewho1` or `savewho2` is high on an armed bit, latch `turn`, load the timer with ANSWER_CYCLES-1, and go to ANSWER.
  - If both are high in the same cycle, P1 wins.
  - A buzz on an unarmed bit is ignored.
- **ANSWER**
  - `arm`=00 and the timer decrements every cycle.
  - `judge_ok`: the answerer's score increments and saturates at 2^SCORE_W-1.
  - `judge_bad`: no score change.
  - `judge_ok` and `judge_bad` together: treated as bad.
  - Timer reaching 0 with no verdict: pulse `timeout`, no score change.
  - A verdict in the same cycle the timer reaches 0 takes the verdict, with no `timeout` pulse.
  - Any outcome goes to CLEAR.
- **CLEAR**
  - `finish`=1 for this one cycle, `turn`=00, `round_cnt`+1.
  - Goes to DONE if `round_cnt`+1 equals ROUNDS, otherwise to ARMED.
- **DONE**
  - `game_over`=1 and `winner` is driven by score comparison.
  - `start` restarts the game as described in IDLE.
- `start` in any state other than IDLE or DONE is ignored.
- Verdicts outside ANSWER are ignored.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `arm`=00, `finish`=0, `turn`=00, `timeout`=0, scores 0, `round_cnt`=0, `game_over`=0, `winner`=00.
- Reset asserted mid-round returns every output to these values immediately (asynchronous).
- Buzz sampled at edge n: `turn` is valid and `arm`=00 after edge n+1.
- Answer window: a verdict is accepted on any of ANSWER_CYCLES consecutive cycles. `timeout` is asserted the cycle after the last of them.
- Verdict at edge n: the score updates at n+1 and `finish` is high during cycle n+1. `arm` re-asserts at n+2.
- `savewho*` stays high until `finish` is seen. ARMED therefore needs `finish` to have cleared them; re-arming one cycle after `finish` is sufficient.

## Configuration
- `QUIZ_LOCKOUT_EN` defined:
  - A player whose round ended in `judge_bad` or `timeout` has their `arm` bit held 0 for the next round only.
  - The lock clears at the following CLEAR and on `start`.
  - If the lockout leaves no player armed, this cannot occur, since only one player is locked at a time.
- Undefined: `arm` is always 11 in ARMED.

## Structure
- Package `quiz_pkg` holds:
  - the state enum (IDLE, ARMED, ANSWER, CLEAR, DONE);
  - `turn`/`winner` code constants: NONE=00, P1=01, P2=10, TIE=11.
- Sub-module `answer_timer`:
  - load and enable inputs, a down counter, and an `expire` output;
  - width $clog2(ANSWER_CYCLES).

## Test plan
- Reset, `start`, `savewho1`=1, `judge_ok` two cycles later → `score1`=1, a single `finish` pulse, `round_cnt`=1, `arm` returns to 11.
- `savewho1` and `savewho2` high in the same cycle → `turn`=01.
- No verdict with ANSWER_CYCLES=16 → `timeout` 16 cycles after entering ANSWER; scores unchanged.
- `judge_ok` and `judge_bad` together → no score change.
- `judge_ok` on the timer's final cycle → point awarded, no `timeout`.
- P1 wins 8 rounds with SCORE_W=2 → `score1` saturates at 3; `game_over`=1 and `winner`=01 after round 8.
- Reset deasserted low mid-ANSWER → all outputs zero at once; the next `start` works normally.
- With `QUIZ_LOCKOUT_EN`, P2 times out → next round `arm`=01 and a P2 buzz is ignored; the round after that, `arm`=11.
